sprite_anim_layer: RTL and testbench

SPRITE_ANIM_LAYER -- requirements
Module: sprite_anim_layer

---
 rtl/sprite_anim_layer.sv | 139 +++++++++++++
 tb/tb_sprite_anim_layer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_layer.sv
// Animated sprite layer: 3-cycle pixel pipeline over an external sprite ROM.
// Optional horizontal mirroring is enabled with `define SPRITE_MIRROR_EN.
module sprite_anim_layer #(
  parameter int          SPR_W     = 64,
  parameter int          SPR_H     = 64,
  parameter int          FRAMES    = 4,
  parameter int          ACTIONS   = 5,
  parameter int          FRAME_DIV = 8,
  parameter int          COORD_W   = 10,
  parameter logic [23:0] TRANSP    = 24'h00FF00,
  localparam int ADDR_W = $clog2(ACTIONS*FRAMES*SPR_H*SPR_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [2:0]         action_sel,
  input  logic               mirror,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [23:0]        rom_data,
  output logic               RqFlag,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b
);

  localparam int DX_W = $clog2(SPR_W);
  localparam int DY_W = $clog2(SPR_H);
  localparam int FI_W = $clog2(FRAMES);

  typedef logic [COORD_W:0] ext_t;

  logic [COORD_W-1:0] sx_q, sy_q;
  logic [2:0]         act_q, act_new;
  logic [FI_W-1:0]    fi_q, fi_d;
  logic [7:0]         tick_q, tick_d;

  logic               hit;
  ext_t               xe, ye, sxe, sye;
  logic [DX_W-1:0]    dx, dxm;
  logic [DY_W-1:0]    dy;
  logic [ADDR_W-1:0]  addr_d, rom_addr_q;
  logic               hit_d1_q, hit_d2_q;
  logic               rq_d, rq_q;
  logic [7:0]         r_q, g_q, b_q;

  assign act_new = (32'(action_sel) >= ACTIONS) ? 3'd0 : action_sel;

  always_comb begin
    fi_d   = fi_q;
    tick_d = tick_q;
    if (act_new != act_q) begin
      fi_d   = '0;
      tick_d = '0;
    end else if (tick_q == 8'(FRAME_DIV - 1)) begin
      fi_d   = fi_q + FI_W'(1);
      tick_d = '0;
    end else begin
      tick_d = tick_q + 8'd1;
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic mir_q;

  always_ff @(posedge clk) begin
    if (!rst_n) mir_q <= 1'b0;
    else if (frame_start) mir_q <= mirror;
  end

  assign dxm = mir_q ? DX_W'(SPR_W - 1) - dx : dx;
`else
  logic unused_mirror;
  assign unused_mirror = mirror;
  assign dxm = dx;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sx_q   <= '0;
      sy_q   <= '0;
      act_q  <= '0;
      fi_q   <= '0;
      tick_q <= '0;
    end else if (frame_start) begin
      sx_q   <= pos_x;
      sy_q   <= pos_y;
      act_q  <= act_new;
      fi_q   <= fi_d;
      tick_q <= tick_d;
    end
  end

  // One extra bit so sx+SPR_W near the right/bottom edge cannot wrap
  assign xe  = {1'b0, x_pos};
  assign ye  = {1'b0, y_pos};
  assign sxe = {1'b0, sx_q};
  assign sye = {1'b0, sy_q};

  assign hit = (xe >= sxe) && (xe < sxe + ext_t'(SPR_W)) &&
               (ye >= sye) && (ye < sye + ext_t'(SPR_H));

  assign dx = x_pos[DX_W-1:0] - sx_q[DX_W-1:0];
  assign dy = y_pos[DY_W-1:0] - sy_q[DY_W-1:0];

  assign addr_d = ADDR_W'({act_q, fi_q, dy, dxm});

  assign rq_d = hit_d2_q && (rom_data != TRANSP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_d1_q   <= 1'b0;
      hit_d2_q   <= 1'b0;
      rom_addr_q <= '0;
      rq_q       <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      hit_d1_q <= hit;
      hit_d2_q <= hit_d1_q;
      if (hit) rom_addr_q <= addr_d;
      rq_q <= rq_d;
      r_q  <= rq_d ? rom_data[23:16] : 8'd0;
      g_q  <= rq_d ? rom_data[15:8]  : 8'd0;
      b_q  <= rq_d ? rom_data[7:0]   : 8'd0;
    end
  end

  assign rom_addr = rom_addr_q;
  assign RqFlag   = rq_q;
  assign r        = r_q;
  assign g        = g_q;
  assign b        = b_q;

endmodule

// File: tb/tb_sprite_anim_layer.sv
// Directed self-checking bench for sprite_anim_layer.
// Expected values are hand-computed for the default parameters.
module tb_sprite_anim_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [9:0]  x_pos, y_pos, pos_x, pos_y;
  logic [2:0]  action_sel;
  logic        mirror;
  logic [16:0] rom_addr;
  logic [23:0] rom_data;
  logic        RqFlag;
  logic [7:0]  r, g, b;

  int checks = 0;
  int errors = 0;

  sprite_anim_layer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .x_pos(x_pos), .y_pos(y_pos), .pos_x(pos_x), .pos_y(pos_y),
    .action_sel(action_sel), .mirror(mirror),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .RqFlag(RqFlag), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    x_pos = 10'd1023;
    y_pos = 10'd1023;
  endtask

  task automatic pulse_fs(input int px, input int py, input int act,
                          input logic mir);
    idle();
    pos_x = 10'(px);
    pos_y = 10'(py);
    action_sel = 3'(act);
    mirror = mir;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulses(input int n, input int px, input int py,
                        input int act);
    for (int i = 0; i < n; i++) pulse_fs(px, py, act, 1'b0);
  endtask

  task automatic pix(input int x, input int y, output logic [16:0] a,
                     output logic q, output logic [23:0] c);
    x_pos = 10'(x);
    y_pos = 10'(y);
    tick();
    a = rom_addr;
    tick();
    tick();
    q = RqFlag;
    c = {r, g, b};
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_start = 1'b0;
    pos_x = '0; pos_y = '0; action_sel = '0; mirror = 1'b0;
    rom_data = 24'hFF8000;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (RqFlag !== 1'b0) begin
      errors++; $display("FAIL reset_rq got %b want 0", RqFlag);
    end
    checks++;
    if ({r, g, b} !== 24'h0) begin
      errors++; $display("FAIL reset_rgb got %h want 000000", {r, g, b});
    end
    checks++;
    if (rom_addr !== 17'd0) begin
      errors++; $display("FAIL reset_addr got %0d want 0", rom_addr);
    end
  endtask

  task automatic test_basic();
    logic [16:0] a; logic q; logic [23:0] c;
    pulse_fs(100, 300, 0, 1'b0);
    rom_data = 24'hFF8000;
    pix(100, 300, a, q, c);
    checks++;
    if (a !== 17'd0) begin
      errors++; $display("FAIL basic_addr got %0d want 0", a);
    end
    checks++;
    if (q !== 1'b1) begin
      errors++; $display("FAIL basic_rq got %b want 1", q);
    end
    checks++;
    if (c !== 24'hFF8000) begin
      errors++; $display("FAIL basic_rgb got %h want FF8000", c);
    end
  endtask

  task automatic test_edges();
    logic [16:0] a; logic q; logic [23:0] c;
    pix(163, 300, a, q, c);
    checks++;
    if (a !== 17'd63 || q !== 1'b1) begin
      errors++; $display("FAIL edge_right got %0d/%b want 63/1", a, q);
    end
    pix(164, 300, a, q, c);
    checks++;
    if (q !== 1'b0 || c !== 24'h0 || a !== 17'd63) begin
      errors++;
      $display("FAIL edge_xmiss got %b/%h/%0d want 0/000000/63", q, c, a);
    end
    pix(100, 364, a, q, c);
    checks++;
    if (q !== 1'b0) begin
      errors++; $display("FAIL edge_ymiss got %b want 0", q);
    end
    pix(163, 363, a, q, c);
    checks++;
    if (a !== 17'd4095 || q !== 1'b1) begin
      errors++; $display("FAIL edge_corner got %0d/%b want 4095/1", a, q);
    end
    rom_data = 24'h00FF00;
    pix(100, 300, a, q, c);
    checks++;
    if (q !== 1'b0 || c !== 24'h0) begin
      errors++; $display("FAIL transp got %b/%h want 0/000000", q, c);
    end
    rom_data = 24'hFF8000;
  endtask

  task automatic test_fs_coincide();
    logic [16:0] a; logic q; logic [23:0] c;
    pos_x = 10'd500; pos_y = 10'd500; action_sel = '0; mirror = 1'b0;
    x_pos = 10'd101; y_pos = 10'd300;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    a = rom_addr;
    idle();
    tick();
    tick();
    q = RqFlag;
    checks++;
    if (a !== 17'd1 || q !== 1'b1) begin
      errors++; $display("FAIL coincide_old got %0d/%b want 1/1", a, q);
    end
    pix(100, 300, a, q, c);
    checks++;
    if (q !== 1'b0) begin
      errors++; $display("FAIL coincide_oldpos got %b want 0", q);
    end
    pix(502, 500, a, q, c);
    checks++;
    if (a !== 17'd2 || q !== 1'b1) begin
      errors++; $display("FAIL coincide_new got %0d/%b want 2/1", a, q);
    end
  endtask

  task automatic test_anim();
    logic [16:0] a; logic q; logic [23:0] c;
    pulse_fs(100, 300, 2, 1'b0);
    pulses(7, 100, 300, 2);
    pix(100, 300, a, q, c);
    checks++;
    if (a !== 17'd32768) begin
      errors++; $display("FAIL anim_7 got %0d want 32768", a);
    end
    pulses(1, 100, 300, 2);
    pix(100, 300, a, q, c);
    checks++;
    if (a !== 17'd36864) begin
      errors++; $display("FAIL anim_8 got %0d want 36864", a);
    end
    pulses(24, 100, 300, 2);
    pix(100, 300, a, q, c);
    checks++;
    if (a !== 17'd32768) begin
      errors++; $display("FAIL anim_32 got %0d want 32768", a);
    end
    pulses(12, 100, 300, 2);
    pulse_fs(100, 300, 1, 1'b0);
    pix(100, 300, a, q, c);
    checks++;
    if (a !== 17'd16384) begin
      errors++; $display("FAIL anim_actchg got %0d want 16384", a);
    end
    pulse_fs(100, 300, 7, 1'b0);
    pix(101, 300, a, q, c);
    checks++;
    if (a !== 17'd1) begin
      errors++; $display("FAIL anim_clamp got %0d want 1", a);
    end
  endtask

  task automatic test_nowrap();
    logic [16:0] a; logic q; logic [23:0] c;
    pulse_fs(1000, 0, 0, 1'b0);
    pix(0, 0, a, q, c);
    checks++;
    if (q !== 1'b0) begin
      errors++; $display("FAIL nowrap got %b want 0", q);
    end
    pix(1023, 63, a, q, c);
    checks++;
    if (a !== 17'd4055 || q !== 1'b1) begin
      errors++; $display("FAIL edge_screen got %0d/%b want 4055/1", a, q);
    end
  endtask

  task automatic test_mirror();
    logic [16:0] a; logic q; logic [23:0] c;
    logic [16:0] exp_a;
`ifdef SPRITE_MIRROR_EN
    exp_a = 17'd63;
`else
    exp_a = 17'd0;
`endif
    pulse_fs(100, 300, 0, 1'b1);
    pix(100, 300, a, q, c);
    checks++;
    if (a !== exp_a) begin
      errors++; $display("FAIL mirror got %0d want %0d", a, exp_a);
    end
    pulse_fs(100, 300, 0, 1'b0);
  endtask

  task automatic test_reset_flush();
    logic seen;
    seen = 1'b0;
    pulse_fs(100, 300, 0, 1'b0);
    x_pos = 10'd100; y_pos = 10'd300;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (RqFlag !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_flush got rq=1 want 0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_fs_coincide();
    test_anim();
    test_nowrap();
    test_mirror();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
